// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's request/response bundle into the RAM arbiter.
// Latency: none, wires only.
// Backpressure: req is held by the master until ack; ack/err/rdata come back from the slave.
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, size, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, size, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin share of one single-port word RAM between two requesters, byte/half stores via read-modify-write.
// Latency grant->ack: load 2, word store 2, byte/half store 4, rejected access 1; one IDLE cycle follows every ack.
// Backpressure: req is held until ack; the losing requester waits, only one transaction is ever in flight.
module ram_arbiter #(
  parameter int   ADDR_W  = 7,
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] MERGE = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;

  logic [2:0]  state;
  logic        prio;
  logic        gnt_id;
  logic        l_we;
  logic        l_err;
  logic [1:0]  l_size;
  logic [1:0]  l_lane;     // byte offset within the word; the word address itself lives in ram_addr
  logic [15:0] l_wdata;    // only the low half is ever merged; word stores go straight to ram_wdata
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        gnt_vld;
  logic        gnt_sel;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic [31:0] merged;

  // A lone request wins outright; a tie goes to whoever holds prio.
  always_comb begin
    gnt_vld   = m0.req | m1.req;
    gnt_sel   = (m0.req && m1.req) ? prio : m1.req;
    sel_we    = gnt_sel ? m1.we    : m0.we;
    sel_size  = gnt_sel ? m1.size  : m0.size;
    sel_addr  = gnt_sel ? m1.addr  : m0.addr;
    sel_wdata = gnt_sel ? m1.wdata : m0.wdata;
  end

  // Reject illegal size, misaligned half/word, and any byte beyond the RAM.
  always_comb begin
    sel_err = (sel_size == 2'd3) ||
              (sel_size == 2'd1 && sel_addr[0]) ||
              (sel_size == 2'd2 && sel_addr[1:0] != 2'b00) ||
              (sel_addr[31:ADDR_W+2] != '0);
  end

  // Replace the stored lane of the word just read with the store data.
  always_comb begin
    merged = ram_rdata;
    if (l_size == 2'd0) begin
      case (l_lane)
        2'd0:    merged[7:0]   = l_wdata[7:0];
        2'd1:    merged[15:8]  = l_wdata[7:0];
        2'd2:    merged[23:16] = l_wdata[7:0];
        default: merged[31:24] = l_wdata[7:0];
      endcase
    end else if (l_lane[1]) begin
      merged[31:16] = l_wdata;
    end else begin
      merged[15:0] = l_wdata;
    end
  end

  // Transaction sequencer: grant, optional read, optional merge, write, then a single ack cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= RR_INIT;
      gnt_id    <= 1'b0;
      l_we      <= 1'b0;
      l_err     <= 1'b0;
      l_size    <= 2'd0;
      l_lane    <= 2'd0;
      l_wdata   <= 16'd0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'd0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            gnt_id  <= gnt_sel;
            prio    <= ~gnt_sel;
            l_we    <= sel_we;
            l_size  <= sel_size;
            l_lane  <= sel_addr[1:0];
            l_wdata <= sel_wdata[15:0];
            l_err   <= sel_err;
            if (sel_err) begin
              state <= ACK;
            end else begin
              ram_addr <= sel_addr[ADDR_W+1:2];
              if (sel_we && sel_size == 2'd2) begin
                ram_wdata <= sel_wdata;
                ram_we    <= 1'b1;
                state     <= WR;
              end else begin
                ram_we <= 1'b0;
                state  <= RD;
              end
            end
          end
        end
        RD: state <= l_we ? MERGE : ACK;
        MERGE: begin
          ram_wdata <= merged;
          ram_we    <= 1'b1;
          state     <= WR;
        end
        WR: begin
          ram_we <= 1'b0;
          state  <= ACK;
        end
        ACK: begin
          if (!l_we && !l_err) begin
            if (gnt_id) rdata1_q <= ram_rdata;
            else        rdata0_q <= ram_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is live from the RAM during a load's ack cycle and held in the per-requester register afterwards.
  assign busy     = (state != IDLE);
  assign m0.ack   = (state == ACK) && !gnt_id;
  assign m1.ack   = (state == ACK) &&  gnt_id;
  assign m0.err   = m0.ack && l_err;
  assign m1.err   = m1.ack && l_err;
  assign m0.rdata = (m0.ack && !l_we && !l_err) ? ram_rdata : rdata0_q;
  assign m1.rdata = (m1.ack && !l_we && !l_err) ? ram_rdata : rdata1_q;
endmodule
